// File: rtl/cmos_dvp_tx.sv
// -----------------------------------------------------------------------------
// cmos_dvp_tx
//
// Camera-side DVP transmitter for an RGB565 capture path. Pixels arrive on a
// valid/ready stream and leave as two bytes each on an 8-bit DVP lane, framed
// as vsync pulse, back porch, active lines and front porch. Everything runs on
// one clock; cam_pclk is clk/2 and is generated from a register.
//
// Handshake: pix_ready is a combinational one-clk strobe raised in the tick
// cycle whose next byte is the high byte of an active pixel. A pixel is
// consumed only when pix_valid & pix_ready in that same cycle. The source must
// not wait for pix_ready before asserting pix_valid; if pix_valid is low at the
// strobe, the pixel slot is sent as 0x00,0x00, the underflow flag sets, and the
// framing carries on without stalling.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active low
//   tx_en        frame enable, looked at only at frame boundaries
//   pix_valid    pix_data holds a pixel
//   pix_data     RGB565 pixel, [15:8] goes out first
//   pix_ready    pop strobe (see handshake above)
//   cam_pclk     pixel clock, clk/2
//   cam_vsync    frame sync, active high
//   cam_href     line valid, active high
//   cam_data     byte lane, zero whenever cam_href is low
//   frame_start  one-clk pulse after the edge where cam_vsync rises
//   busy         high from frame start until the edge that enters IDLE
//   underflow    sticky, set when a pixel is needed and pix_valid is low
//   dbg_state    current framing state (IDLE=0 VSYNC=1 VBACK=2 ACTIVE=3 VFRONT=4)
// -----------------------------------------------------------------------------
module cmos_dvp_tx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 4,
  parameter int V_BACK   = 18,
  parameter int V_FRONT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic        busy,
  output logic        underflow,
  output logic [2:0]  dbg_state
);

  // Bytes per line, identical for every line type.
  localparam int          LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
  localparam logic [11:0] C_H_LAST   = 12'(LINE_BYTES - 1);
  localparam logic [11:0] C_H_ACT    = 12'(2 * H_ACTIVE);
  localparam logic [11:0] C_VS_LAST  = 12'(VS_LINES - 1);
  localparam logic [11:0] C_VB_LAST  = 12'(V_BACK - 1);
  localparam logic [11:0] C_VA_LAST  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] C_VF_LAST  = 12'(V_FRONT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  // Registered state. r_state/r_h_cnt/r_v_cnt describe the byte currently
  // on the lane, so they and the DVP outputs move together on a tick.
  state_t      r_state;
  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        r_pclk;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_data;
  logic [7:0]  r_lo;
  logic        r_fs;
  logic        r_busy;
  logic        r_uf;

  // Next-position logic.
  state_t      w_state_nxt;
  logic [11:0] w_h_nxt;
  logic [11:0] w_v_nxt;
  logic [11:0] w_v_last;
  logic        w_tick;
  logic        w_line_end;
  logic        w_blk_end;
  logic        w_frame_go;
  logic        w_act_byte;
  logic        w_pop;

  // A tick is the clk cycle in which cam_pclk is high: the following edge
  // drops pclk, so data launched there is stable across the pclk rise.
  assign w_tick = r_pclk;

  // Terminal line index of the current region.
  always_comb begin
    w_v_last = 12'd0;
    case (r_state)
      S_VSYNC:  w_v_last = C_VS_LAST;
      S_VBACK:  w_v_last = C_VB_LAST;
      S_ACTIVE: w_v_last = C_VA_LAST;
      S_VFRONT: w_v_last = C_VF_LAST;
      default:  w_v_last = 12'd0;
    endcase
  end

  assign w_line_end = (r_h_cnt == C_H_LAST);
  assign w_blk_end  = w_line_end && (r_v_cnt == w_v_last);

  // Next state and counters, applied only on a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (tx_en) begin
            w_state_nxt = S_VSYNC;
            w_h_nxt     = 12'd0;
            w_v_nxt     = 12'd0;
          end
        end
        default: begin
          if (w_line_end) begin
            w_h_nxt = 12'd0;
            if (w_blk_end) begin
              w_v_nxt = 12'd0;
              case (r_state)
                S_VSYNC:  w_state_nxt = S_VBACK;
                S_VBACK:  w_state_nxt = S_ACTIVE;
                S_ACTIVE: w_state_nxt = S_VFRONT;
                // Frame boundary: tx_en decides between back-to-back and idle.
                S_VFRONT: w_state_nxt = tx_en ? S_VSYNC : S_IDLE;
                default:  w_state_nxt = S_IDLE;
              endcase
            end else begin
              w_v_nxt = r_v_cnt + 12'd1;
            end
          end else begin
            w_h_nxt = r_h_cnt + 12'd1;
          end
        end
      endcase
    end
  end

  // A new frame begins whenever VSYNC is entered from outside VSYNC.
  assign w_frame_go = w_tick && (w_state_nxt == S_VSYNC) &&
                      ((r_state == S_IDLE) || (r_state == S_VFRONT));

  // Next byte is inside the active part of an active line.
  assign w_act_byte = (w_state_nxt == S_ACTIVE) && (w_h_nxt < C_H_ACT);

  // Even active byte -> high byte of a fresh pixel -> pop.
  assign w_pop = w_tick && w_act_byte && !w_h_nxt[0];

  // Gated by rst_n so no pop is offered in a cycle that is being reset.
  assign pix_ready = rst_n && w_pop;

  // State and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
      r_pclk  <= 1'b0;
    end else begin
      r_pclk <= ~r_pclk;
      if (w_tick) begin
        r_state <= w_state_nxt;
        r_h_cnt <= w_h_nxt;
        r_v_cnt <= w_v_nxt;
      end
    end
  end

  // Registered DVP outputs and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_data  <= 8'h00;
      r_lo    <= 8'h00;
      r_fs    <= 1'b0;
      r_busy  <= 1'b0;
      r_uf    <= 1'b0;
    end else begin
      r_fs <= w_frame_go;
      if (w_tick) begin
        r_vsync <= (w_state_nxt == S_VSYNC);
        r_href  <= w_act_byte;
        r_busy  <= (w_state_nxt != S_IDLE);
        if (w_pop) begin
          if (pix_valid) begin
            r_data <= pix_data[15:8];
            r_lo   <= pix_data[7:0];
          end else begin
            // Missing pixel: send a black slot, keep the source's pixel.
            r_data <= 8'h00;
            r_lo   <= 8'h00;
            r_uf   <= 1'b1;
          end
        end else if (w_act_byte) begin
          r_data <= r_lo;
        end else begin
          r_data <= 8'h00;
        end
      end
    end
  end

  assign cam_pclk    = r_pclk;
  assign cam_vsync   = r_vsync;
  assign cam_href    = r_href;
  assign cam_data    = r_data;
  assign frame_start = r_fs;
  assign busy        = r_busy;
  assign underflow   = r_uf;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// -----------------------------------------------------------------------------
// tb_cmos_dvp_tx: self-checking bench for cmos_dvp_tx in the small framing
// configuration (L=10 bytes per line, 50-byte frames).
// The reference model tracks a frame as a plain byte index and derives
// vsync/href/data from line = byte/L and h = byte%L.
// -----------------------------------------------------------------------------
module tb_cmos_dvp_tx;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HB = 2;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int L  = 2 * HA + HB;
  localparam int F  = (VS + VB + VA + VF) * L;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_start;
  logic        busy;
  logic        underflow;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  cmos_dvp_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VS_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .frame_start(frame_start), .busy(busy),
    .underflow(underflow), .dbg_state(dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- source and scoreboard ----------------
  logic [15:0] src_q[$];
  logic [7:0]  exp_q[$];
  logic        drv_valid;
  int          stall_pop;
  int          dut_pops;
  int          fs_q[$];
  int          idle_q[$];
  logic        prev_busy;

  // ---------------- reference model ----------------
  logic       m_pclk, m_tick, m_run, m_vs, m_hr, m_fs, m_busy, m_uf;
  logic [7:0] m_data, m_lo;
  int         m_byte, m_pops;

  function automatic logic is_active(input int b);
    int line;
    line = b / L;
    return (line >= VS + VB) && (line < VS + VB + VA) && ((b % L) < 2 * HA);
  endfunction

  function automatic logic pop_next();
    int nb;
    if (!rst_n || !m_pclk || !m_run) return 1'b0;
    nb = m_byte + 1;
    if (nb >= F) return 1'b0;
    return is_active(nb) && ((nb % L) % 2 == 0);
  endfunction

  function automatic logic [2:0] exp_state();
    int line;
    if (!m_run) return 3'd0;
    line = m_byte / L;
    if (line < VS) return 3'd1;
    if (line < VS + VB) return 3'd2;
    if (line < VS + VB + VA) return 3'd3;
    return 3'd4;
  endfunction

  task automatic model_reset();
    m_pclk = 0; m_tick = 0; m_run = 0; m_vs = 0; m_hr = 0; m_fs = 0;
    m_busy = 0; m_uf = 0; m_data = 0; m_lo = 0; m_byte = 0; m_pops = 0;
    exp_q.delete();
  endtask

  task automatic model_clock();
    int h;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_tick = m_pclk;
    m_pclk = ~m_pclk;
    m_fs   = 1'b0;
    if (!m_tick) return;
    if (!m_run) begin
      if (tx_en) begin m_run = 1; m_byte = 0; m_fs = 1; m_pops = 0; end
    end else if (m_byte == F - 1) begin
      if (tx_en) begin m_byte = 0; m_fs = 1; m_pops = 0; end
      else m_run = 0;
    end else begin
      m_byte++;
    end
    m_busy = m_run; m_vs = 0; m_hr = 0; m_data = 0;
    if (m_run) begin
      h    = m_byte % L;
      m_vs = (m_byte / L) < VS;
      if (is_active(m_byte)) begin
        m_hr = 1;
        if (h % 2 == 0) begin
          m_pops++;
          if (pix_valid) begin
            m_data = pix_data[15:8];
            m_lo   = pix_data[7:0];
            void'(src_q.pop_front());
          end else begin
            m_data = 8'h00; m_lo = 8'h00; m_uf = 1;
          end
        end else begin
          m_data = m_lo;
        end
        exp_q.push_back(m_data);
      end
    end
  endtask

  // ---------------- per-byte capture for table checks ----------------
  logic       cap_en;
  logic       cap_vs[F];
  logic       cap_hr[F];
  logic [7:0] cap_d[F];

  task automatic cap_clear();
    for (int i = 0; i < F; i++) begin
      cap_vs[i] = 1'bx; cap_hr[i] = 1'bx; cap_d[i] = 8'hxx;
    end
  endtask

  // ---------------- driver: one clk per call, called at negedge ----------------
  task automatic step();
    logic pn;
    pn        = pop_next();
    pix_data  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
    pix_valid = drv_valid && (src_q.size() > 0) && !(pn && (m_pops == stall_pop));
    #1;
    chk("pix_ready", {15'd0, pix_ready}, {15'd0, pn});
    if (pix_ready && pix_valid) dut_pops++;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    cyc++;
    chk("cam_pclk",    {15'd0, cam_pclk},    {15'd0, m_pclk});
    chk("cam_vsync",   {15'd0, cam_vsync},   {15'd0, m_vs});
    chk("cam_href",    {15'd0, cam_href},    {15'd0, m_hr});
    chk("cam_data",    {8'd0, cam_data},     {8'd0, m_data});
    chk("frame_start", {15'd0, frame_start}, {15'd0, m_fs});
    chk("busy",        {15'd0, busy},        {15'd0, m_busy});
    chk("underflow",   {15'd0, underflow},   {15'd0, m_uf});
    chk("dbg_state",   {13'd0, dbg_state},   {13'd0, exp_state()});
    if (rst_n && m_tick && cam_href) begin
      if (exp_q.size() == 0) chk("sb_unexpected_byte", {8'd0, cam_data}, 16'hffff);
      else chk("sb_byte", {8'd0, cam_data}, {8'd0, exp_q.pop_front()});
    end
    if (frame_start) fs_q.push_back(cyc);
    if (prev_busy && !busy) idle_q.push_back(cyc);
    prev_busy = busy;
    if (cap_en && rst_n && m_tick && m_run) begin
      cap_vs[m_byte] = cam_vsync;
      cap_hr[m_byte] = cam_href;
      cap_d[m_byte]  = cam_data;
    end
  endtask

  task automatic run_to_idle(input string name, input int budget);
    int k;
    k = 0;
    while (idle_q.size() == 0 && k < budget) begin step(); k++; end
    chk(name, {15'd0, idle_q.size() > 0}, 16'd1);
  endtask

  task automatic run_to_fs(input string name, input int budget);
    int k;
    k = 0;
    while (fs_q.size() == 0 && k < budget) begin step(); k++; end
    chk(name, {15'd0, fs_q.size() > 0}, 16'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         set;   // 0: single frame, 1: underflow frame
    int         b;     // byte index in frame
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } vec_t;
  vec_t vecs[$];

  task automatic apply_table(input int set, input string tag);
    foreach (vecs[i]) begin
      if (vecs[i].set == set) begin
        chk({tag, "_vsync"}, {15'd0, cap_vs[vecs[i].b]}, {15'd0, vecs[i].vs});
        chk({tag, "_href"},  {15'd0, cap_hr[vecs[i].b]}, {15'd0, vecs[i].hr});
        chk({tag, "_data"},  {8'd0, cap_d[vecs[i].b]},   {8'd0, vecs[i].d});
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // single frame: pixels 1234 5678 9ABC DEF0 1357 2468 ACE0 BDF1
    vecs.push_back('{0,  0, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{0,  9, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{0, 10, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{0, 19, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{0, 20, 1'b0, 1'b1, 8'h12});
    vecs.push_back('{0, 21, 1'b0, 1'b1, 8'h34});
    vecs.push_back('{0, 22, 1'b0, 1'b1, 8'h56});
    vecs.push_back('{0, 23, 1'b0, 1'b1, 8'h78});
    vecs.push_back('{0, 26, 1'b0, 1'b1, 8'hDE});
    vecs.push_back('{0, 27, 1'b0, 1'b1, 8'hF0});
    vecs.push_back('{0, 28, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{0, 29, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{0, 30, 1'b0, 1'b1, 8'h13});
    vecs.push_back('{0, 31, 1'b0, 1'b1, 8'h57});
    vecs.push_back('{0, 37, 1'b0, 1'b1, 8'hF1});
    vecs.push_back('{0, 38, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{0, 40, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{0, 49, 1'b0, 1'b0, 8'h00});
    // underflow frame: A1B2 C3D4 <stall> E5F6 0718 293A 4B5C 6D7E
    vecs.push_back('{1, 20, 1'b0, 1'b1, 8'hA1});
    vecs.push_back('{1, 21, 1'b0, 1'b1, 8'hB2});
    vecs.push_back('{1, 22, 1'b0, 1'b1, 8'hC3});
    vecs.push_back('{1, 23, 1'b0, 1'b1, 8'hD4});
    vecs.push_back('{1, 24, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{1, 25, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{1, 26, 1'b0, 1'b1, 8'hE5});
    vecs.push_back('{1, 27, 1'b0, 1'b1, 8'hF6});
    vecs.push_back('{1, 28, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1, 30, 1'b0, 1'b1, 8'h07});
    vecs.push_back('{1, 31, 1'b0, 1'b1, 8'h18});
    vecs.push_back('{1, 36, 1'b0, 1'b1, 8'h6D});
    vecs.push_back('{1, 37, 1'b0, 1'b1, 8'h7E});

    rst_n = 1'b0; tx_en = 1'b1; drv_valid = 1'b1; stall_pop = -1;
    pix_valid = 1'b0; pix_data = 16'h0; cap_en = 1'b0; prev_busy = 1'b0;
    dut_pops = 0;
    model_reset();
    @(negedge clk);

    // 1. reset held with tx_en=1
    repeat (3) step();
    chk("rst_pclk",  {15'd0, cam_pclk},  16'd0);
    chk("rst_vsync", {15'd0, cam_vsync}, 16'd0);
    chk("rst_href",  {15'd0, cam_href},  16'd0);
    chk("rst_data",  {8'd0, cam_data},   16'd0);
    chk("rst_busy",  {15'd0, busy},      16'd0);
    chk("rst_fs",    {15'd0, frame_start}, 16'd0);
    chk("rst_uf",    {15'd0, underflow}, 16'd0);
    chk("rst_state", {13'd0, dbg_state}, 16'd0);

    // 2. single frame, tx_en for one tick only
    src_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1357, 16'h2468, 16'hACE0, 16'hBDF1};
    cap_clear(); cap_en = 1'b1; fs_q.delete(); idle_q.delete(); dut_pops = 0;
    rst_n = 1'b1;
    step();
    chk("rel_pclk_high", {15'd0, cam_pclk}, 16'd1);
    chk("rel_vsync_low", {15'd0, cam_vsync}, 16'd0);
    step();
    chk("first_tick_vsync", {15'd0, cam_vsync}, 16'd1);
    chk("first_tick_fs",    {15'd0, frame_start}, 16'd1);
    chk("first_tick_busy",  {15'd0, busy}, 16'd1);
    tx_en = 1'b0;
    step();
    chk("fs_one_clk", {15'd0, frame_start}, 16'd0);
    run_to_idle("s2_idle_timeout", 150);
    cap_en = 1'b0;
    if (idle_q.size() > 0 && fs_q.size() > 0)
      chk("s2_frame_clk", 16'(idle_q[0] - fs_q[0]), 16'd100);
    chk("s2_pops", 16'(dut_pops), 16'd8);
    chk("s2_state_idle", {13'd0, dbg_state}, 16'd0);
    apply_table(0, "s2");

    // 3. back-to-back frames
    repeat (5) step();
    for (int i = 0; i < 3 * HA * VA; i++) src_q.push_back(16'($urandom));
    fs_q.delete(); idle_q.delete();
    tx_en = 1'b1;
    begin
      int k;
      k = 0;
      while (fs_q.size() < 3 && k < 400) begin step(); k++; end
      chk("s3_fs_timeout", {15'd0, fs_q.size() >= 3}, 16'd1);
    end
    tx_en = 1'b0;
    run_to_idle("s3_idle_timeout", 200);
    if (fs_q.size() >= 3 && idle_q.size() > 0) begin
      chk("s3_fs_gap0", 16'(fs_q[1] - fs_q[0]), 16'd100);
      chk("s3_fs_gap1", 16'(fs_q[2] - fs_q[1]), 16'd100);
      chk("s3_busy_fall", 16'(idle_q[0] - fs_q[2]), 16'd100);
    end
    chk("s3_one_busy_fall", 16'(idle_q.size()), 16'd1);

    // 5. enable drop during first active line
    repeat (3) step();
    for (int i = 0; i < HA * VA; i++) src_q.push_back(16'($urandom));
    fs_q.delete(); idle_q.delete();
    tx_en = 1'b1;
    run_to_fs("s5_fs_timeout", 10);
    begin
      int k;
      k = 0;
      while (!(m_run && m_byte >= 22) && k < 60) begin step(); k++; end
    end
    tx_en = 1'b0;
    run_to_idle("s5_idle_timeout", 120);
    if (fs_q.size() > 0 && idle_q.size() > 0)
      chk("s5_frame_clk", 16'(idle_q[0] - fs_q[0]), 16'd100);
    repeat (10) step();
    chk("s5_no_restart", 16'(fs_q.size()), 16'd1);
    chk("s5_busy_low", {15'd0, busy}, 16'd0);

    // 4. underflow at the 3rd pop
    chk("s4_uf_before", {15'd0, underflow}, 16'd0);
    src_q = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
    cap_clear(); cap_en = 1'b1; stall_pop = 2;
    fs_q.delete(); idle_q.delete();
    tx_en = 1'b1;
    run_to_fs("s4_fs_timeout", 10);
    tx_en = 1'b0;
    run_to_idle("s4_idle_timeout", 150);
    cap_en = 1'b0; stall_pop = -1;
    if (fs_q.size() > 0 && idle_q.size() > 0)
      chk("s4_frame_clk", 16'(idle_q[0] - fs_q[0]), 16'd100);
    chk("s4_uf_sticky", {15'd0, underflow}, 16'd1);
    chk("s4_left_in_src", 16'(src_q.size()), 16'd1);
    apply_table(1, "s4");
    src_q.delete();
    repeat (6) step();
    chk("s4_uf_still", {15'd0, underflow}, 16'd1);

    // 6. mid-line reset at byte 23
    for (int i = 0; i < 2 * HA * VA; i++) src_q.push_back(16'($urandom));
    fs_q.delete(); idle_q.delete();
    tx_en = 1'b1;
    begin
      int k;
      k = 0;
      while (!(m_run && m_tick && m_byte == 23) && k < 100) begin step(); k++; end
      chk("s6_reach_timeout", {15'd0, m_run && m_byte == 23}, 16'd1);
    end
    rst_n = 1'b0;
    step();
    chk("s6_rst_pclk",  {15'd0, cam_pclk},  16'd0);
    chk("s6_rst_href",  {15'd0, cam_href},  16'd0);
    chk("s6_rst_data",  {8'd0, cam_data},   16'd0);
    chk("s6_rst_busy",  {15'd0, busy},      16'd0);
    chk("s6_rst_uf",    {15'd0, underflow}, 16'd0);
    chk("s6_rst_state", {13'd0, dbg_state}, 16'd0);
    rst_n = 1'b1;
    fs_q.delete(); idle_q.delete();
    run_to_fs("s6_fs_timeout", 10);
    chk("s6_vsync_fresh", {15'd0, cam_vsync}, 16'd1);
    chk("s6_state_vsync", {13'd0, dbg_state}, 16'd1);
    tx_en = 1'b0;
    run_to_idle("s6_idle_timeout", 150);
    if (fs_q.size() > 0 && idle_q.size() > 0)
      chk("s6_frame_clk", 16'(idle_q[0] - fs_q[0]), 16'd100);
    src_q.delete();

    // randomized: tx_en toggling, sparse valid gaps, occasional reset
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 149) == 0) tx_en = ~tx_en;
      drv_valid = ($urandom_range(0, 15) != 0);
      rst_n     = ($urandom_range(0, 399) != 0);
      while (src_q.size() < 4) src_q.push_back(16'($urandom));
      step();
    end
    rst_n = 1'b1; tx_en = 1'b0; drv_valid = 1'b1;
    idle_q.delete();
    if (busy) run_to_idle("end_idle_timeout", 150);
    repeat (4) step();
    chk("end_state_idle", {13'd0, dbg_state}, 16'd0);
    chk("sb_leftover", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
